// File: rtl/button_pio_pkg.sv
// Shared constants for the button PIO: register word addresses and
// the debounce counter sizing helper.
package button_pio_pkg;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_MASK = 2'd1;
  localparam logic [1:0] REG_ECAP = 2'd2;
  localparam logic [1:0] REG_ESEL = 2'd3;

  // Counter only has to reach DEBOUNCE_CYCLES-1; keep at least one bit.
  function automatic int cnt_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One button channel: optional inversion, 2-flop synchroniser, debounce
// counter and the accepted level plus its one-cycle-delayed copy.
module button_debounce
  import button_pio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic stable_d
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          level;
  logic          sync1;
  logic          s;
  logic [CW-1:0] cnt;

  assign level = ACTIVE_LOW ? ~raw : raw;

  // A new level is accepted only after DEBOUNCE_CYCLES consecutive
  // disagreeing samples; any agreeing sample restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1    <= 1'b0;
      s        <= 1'b0;
      cnt      <= '0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
    end else begin
      sync1    <= level;
      s        <= sync1;
      stable_d <= stable;
      if (s == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= s;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_pio_irq.sv
// Avalon-MM button/key PIO with per-channel debounce, selectable edge
// capture (sticky, write-1-to-clear) and a maskable level interrupt.
module button_pio_irq
  import button_pio_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] btn_in,
  input  logic [1:0]      avs_address,
  input  logic            avs_read,
  input  logic            avs_write,
  input  logic [31:0]     avs_writedata,
  output logic [31:0]     avs_readdata,
  output logic            irq
);

  logic [N_CH-1:0] stable;
  logic [N_CH-1:0] stable_d;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;
  logic [N_CH-1:0] ev;
  logic [N_CH-1:0] irq_mask;
  logic [N_CH-1:0] edge_cap;
  logic [N_CH-1:0] edge_sel;
  logic [N_CH-1:0] wdata;
  logic [N_CH-1:0] w1c;
  logic [31:0]     rd_mux;
  logic            unused_wdata;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_deb (
      .clk     (clk),
      .reset   (reset),
      .raw     (btn_in[i]),
      .stable  (stable[i]),
      .stable_d(stable_d[i])
    );
  end

  assign rise  = stable & ~stable_d;
  assign fall  = ~stable & stable_d;
  assign ev    = (edge_sel & fall) | (~edge_sel & rise);
  assign wdata = avs_writedata[N_CH-1:0];
  assign w1c   = (avs_write && avs_address == REG_ECAP) ? wdata : '0;
  assign unused_wdata = ^avs_writedata;

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      REG_DATA: rd_mux = 32'(stable);
      REG_MASK: rd_mux = 32'(irq_mask);
      REG_ECAP: rd_mux = 32'(edge_cap);
      REG_ESEL: rd_mux = 32'(edge_sel);
      default:  rd_mux = '0;
    endcase
  end

  // Capture is applied after the clear so a same-cycle event is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_mask     <= '0;
      edge_cap     <= '0;
      edge_sel     <= '0;
      avs_readdata <= '0;
      irq          <= 1'b0;
    end else begin
      edge_cap <= (edge_cap & ~w1c) | ev;
      if (avs_write && avs_address == REG_MASK) irq_mask <= wdata;
      if (avs_write && avs_address == REG_ESEL) edge_sel <= wdata;
      if (avs_read) avs_readdata <= rd_mux;
      irq <= |(edge_cap & irq_mask);
    end
  end

endmodule

// File: tb/tb_button_pio_irq.sv
// Directed bench for button_pio_irq with a short debounce window.
module tb_button_pio_irq;

  localparam int N_CH = 4;
  localparam int DC   = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N_CH-1:0] btn_in;
  logic [1:0]      avs_address;
  logic            avs_read;
  logic            avs_write;
  logic [31:0]     avs_writedata;
  logic [31:0]     avs_readdata;
  logic            irq;

  int errors = 0;
  int checks = 0;

  button_pio_irq #(.N_CH(N_CH), .DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(1'b0)) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_in       (btn_in),
    .avs_address  (avs_address),
    .avs_read     (avs_read),
    .avs_write    (avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata (avs_readdata),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  // All tasks start and end at 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    avs_address = a;
    avs_read    = 1'b1;
    step();
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    step();
    avs_write = 1'b0;
  endtask

  task automatic wait_stable(input int ch, input logic v, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (dut.stable[ch] !== v && n < 30);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1; btn_in = '0; avs_address = '0; avs_read = 0; avs_write = 0; avs_writedata = '0;
    step(); step();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%0b exp=0", irq); end
    checks++; if (avs_readdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", avs_readdata); end
    reset = 1'b0;
    step();
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_reg%0d got=%h exp=0", a, d); end
    end
  endtask

  task automatic test_press();
    logic [31:0] d;
    int n;
    btn_in[0] = 1'b1;
    wait_stable(0, 1'b1, n);
    checks++; if (n !== 2 + DC) begin errors++; $display("FAIL press_latency got=%0d exp=%0d", n, 2 + DC); end
    rd(0, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL press_data got=%h exp=1", d); end
    rd(2, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL press_ecap got=%h exp=1", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL press_irq_masked got=%0b exp=0", irq); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    wr(1, 32'h1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_mask_early got=%0b exp=0", irq); end
    step();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_assert got=%0b exp=1", irq); end
    wr(2, 32'h1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_clear_early got=%0b exp=1", irq); end
    step();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_deassert got=%0b exp=0", irq); end
    rd(2, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL irq_ecap_cleared got=%h exp=0", d); end
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    btn_in[2] = 1'b1;
    repeat (3) step();
    btn_in[2] = 1'b0;
    repeat (6) step();
    checks++; if (dut.g_ch[2].u_deb.cnt !== '0) begin errors++; $display("FAIL glitch_cnt got=%0d exp=0", dut.g_ch[2].u_deb.cnt); end
    rd(0, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL glitch_data got=%h exp=1", d); end
    rd(2, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL glitch_ecap got=%h exp=0", d); end
  endtask

  task automatic test_falling();
    logic [31:0] d;
    wr(3, 32'h2);
    rd(3, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL esel_read got=%h exp=2", d); end
    btn_in[1] = 1'b1;
    repeat (10) step();
    rd(2, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL fall_on_press got=%h exp=0", d); end
    btn_in[1] = 1'b0;
    repeat (10) step();
    rd(2, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL fall_on_release got=%h exp=2", d); end
    wr(2, 32'h2);
  endtask

  task automatic test_set_wins();
    logic [31:0] d;
    btn_in[3] = 1'b1;
    repeat (2 + DC) step();
    // ev[3] is high between the stable change and the next edge.
    wr(2, 32'h8);
    rd(2, d);
    checks++; if (d !== 32'h8) begin errors++; $display("FAIL set_wins got=%h exp=8", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    avs_address = 2'd1; avs_writedata = 32'hFFFF_FFFF; avs_read = 1'b1; avs_write = 1'b1;
    step();
    avs_read = 1'b0; avs_write = 1'b0;
    checks++; if (avs_readdata !== 32'h1) begin errors++; $display("FAIL rw_same_cycle got=%h exp=1", avs_readdata); end
    rd(1, d);
    checks++; if (d !== 32'hF) begin errors++; $display("FAIL mask_width got=%h exp=f", d); end
    wr(0, 32'hF);
    rd(0, d);
    checks++; if (d !== 32'h9) begin errors++; $display("FAIL data_ro got=%h exp=9", d); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_mask_all got=%0b exp=1", irq); end
    step();
    checks++; if (avs_readdata !== 32'h9) begin errors++; $display("FAIL rdata_hold got=%h exp=9", avs_readdata); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int n;
    btn_in = '0;
    repeat (10) step();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL pre_reset_irq got=%0b exp=1", irq); end
    btn_in[0] = 1'b1;
    repeat (4) step();
    reset = 1'b1;
    #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_reset_irq got=%0b exp=0", irq); end
    checks++; if (avs_readdata !== 32'h0) begin errors++; $display("FAIL mid_reset_rdata got=%h exp=0", avs_readdata); end
    checks++; if (dut.stable !== 4'h0) begin errors++; $display("FAIL mid_reset_stable got=%h exp=0", dut.stable); end
    step(); step();
    reset = 1'b0;
    wait_stable(0, 1'b1, n);
    checks++; if (n !== 2 + DC) begin errors++; $display("FAIL post_reset_latency got=%0d exp=%0d", n, 2 + DC); end
    rd(0, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL post_reset_data got=%h exp=1", d); end
    rd(2, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL post_reset_ecap got=%h exp=1", d); end
    rd(1, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL post_reset_mask got=%h exp=0", d); end
    rd(3, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL post_reset_esel got=%h exp=0", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL post_reset_irq got=%0b exp=0", irq); end
  endtask

  initial begin
    test_reset();
    test_press();
    test_irq();
    test_glitch();
    test_falling();
    test_set_wins();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
